// File: rtl/ofdm_qpsk_demapper_pkg.sv
// ofdm_pkg: shared constants and FSM state type for the OFDM QPSK demapper.
// Symbol geometry is fixed at 16 bins, 2 bits per bin and 8-bit bytes.
package ofdm_pkg;

    localparam int POINTS           = 16;
    localparam int BITS_PER_SYMBOL  = 2 * POINTS;
    localparam int BYTES_PER_SYMBOL = BITS_PER_SYMBOL / 8;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

endpackage

// File: rtl/ofdm_qpsk_demapper_qpsk_slicer.sv
// qpsk_slicer: hard QPSK decision for one FFT bin.
// The sign bit of each component is the decided bit, so zero decides 0.
// With OFDM_DEMAP_ERASURE_EN defined it also flags low-magnitude bins.
module qpsk_slicer #(
    parameter int WORD_SIZE = 16
`ifdef OFDM_DEMAP_ERASURE_EN
    ,
    parameter int ERASE_THR = 16
`endif
) (
    input  logic [WORD_SIZE-1:0] re,
    input  logic [WORD_SIZE-1:0] im,
    output logic [1:0]           bits
`ifdef OFDM_DEMAP_ERASURE_EN
    ,
    output logic                 erase
`endif
);

    assign bits = {im[WORD_SIZE-1], re[WORD_SIZE-1]};

`ifdef OFDM_DEMAP_ERASURE_EN
    localparam logic [WORD_SIZE-1:0] THR     = WORD_SIZE'(ERASE_THR);
    localparam logic [WORD_SIZE-1:0] MOST_NEG = {1'b1, {(WORD_SIZE-1){1'b0}}};
    localparam logic [WORD_SIZE-1:0] MOST_POS = {1'b0, {(WORD_SIZE-1){1'b1}}};

    // Magnitude of a two's complement sample; the most negative value
    // saturates to the most positive one instead of wrapping.
    function automatic logic [WORD_SIZE-1:0] sat_abs(input logic [WORD_SIZE-1:0] x);
        if (x == MOST_NEG) begin
            return MOST_POS;
        end else if (x[WORD_SIZE-1]) begin
            return (~x) + {{(WORD_SIZE-1){1'b0}}, 1'b1};
        end else begin
            return x;
        end
    endfunction

    assign erase = (sat_abs(re) < THR) | (sat_abs(im) < THR);
`endif

endmodule

// File: rtl/ofdm_qpsk_demapper.sv
// ofdm_qpsk_demapper: latches a 16-bin FFT result on the cycle-done strobe,
// slices each bin to two QPSK bits and streams the 32-bit symbol out as four
// bytes over a valid/ready handshake. Byte n holds bins 4n..4n+3.
// Optional feature macro: OFDM_DEMAP_ERASURE_EN (per-byte erasure flag).
module ofdm_qpsk_demapper
    import ofdm_pkg::*;
#(
    parameter int WORD_SIZE   = 16,
    parameter int DATA_LENGTH = 8,
    parameter int FRACTION    = 8,
    parameter int STAGES      = 4,
    parameter int ERASE_THR   = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [POINTS*WORD_SIZE-1:0]   i_bins_re,
    input  logic [POINTS*WORD_SIZE-1:0]   i_bins_im,
    input  logic                          i_FFT_cycle_done,
    output logic [DATA_LENGTH-1:0]        o_byte,
    output logic                          o_byte_valid,
    input  logic                          i_byte_ready,
    output logic                          o_busy,
    output logic                          o_overrun,
    output logic                          o_erasure
);

    localparam int BINS_PER_BYTE = DATA_LENGTH / 2;
    localparam int IDX_W         = $clog2(BYTES_PER_SYMBOL);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_SYMBOL - 1);

    // Parameter sanity: geometry must match the package and the threshold
    // must be representable as a positive sample magnitude.
    if ((STAGES != $clog2(POINTS)) || (DATA_LENGTH * BYTES_PER_SYMBOL != BITS_PER_SYMBOL) ||
        (FRACTION >= WORD_SIZE) || (ERASE_THR < 0) || (ERASE_THR >= (2 ** (WORD_SIZE - 1)))) begin : g_bad_cfg
        $error("ofdm_qpsk_demapper: unsupported parameter combination");
    end

    logic [BITS_PER_SYMBOL-1:0] dec_s;
    logic [BITS_PER_SYMBOL-1:0] sym_r;
    logic [IDX_W-1:0]           idx_r;
    logic [IDX_W-1:0]           nxt_idx_s;
    logic [DATA_LENGTH-1:0]     byte_r;
    logic                       valid_r;
    logic                       busy_r;
    logic                       overrun_r;
    logic                       hs_s;
    logic                       last_s;
    logic                       cap_s;
    logic                       adv_s;
    state_t                     state_r;

`ifdef OFDM_DEMAP_ERASURE_EN
    logic [POINTS-1:0] era_s;
    logic [POINTS-1:0] era_r;
    logic              erasure_r;
`endif

    for (genvar k = 0; k < POINTS; k++) begin : g_bin
        qpsk_slicer #(
            .WORD_SIZE (WORD_SIZE)
`ifdef OFDM_DEMAP_ERASURE_EN
            ,
            .ERASE_THR (ERASE_THR)
`endif
        ) u_slicer (
            .re   (i_bins_re[k*WORD_SIZE +: WORD_SIZE]),
            .im   (i_bins_im[k*WORD_SIZE +: WORD_SIZE]),
            .bits (dec_s[2*k +: 2])
`ifdef OFDM_DEMAP_ERASURE_EN
            ,
            .erase(era_s[k])
`endif
        );
    end

    // valid_r is only ever high in EMIT, so a handshake implies EMIT.
    assign hs_s      = valid_r & i_byte_ready;
    assign last_s    = hs_s & (idx_r == LAST_IDX);
    assign cap_s     = i_FFT_cycle_done & ((state_r == ST_IDLE) | last_s);
    assign adv_s     = hs_s & ~last_s;
    assign nxt_idx_s = idx_r + {{(IDX_W-1){1'b0}}, 1'b1};

    // Control FSM: capture on strobe, step through bytes on handshakes,
    // flag strobes that arrive while a symbol is still being drained.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_r   <= ST_IDLE;
            sym_r     <= {BITS_PER_SYMBOL{1'b0}};
            idx_r     <= {IDX_W{1'b0}};
            byte_r    <= {DATA_LENGTH{1'b0}};
            valid_r   <= 1'b0;
            busy_r    <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            overrun_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (cap_s) begin
                        state_r <= ST_EMIT;
                        sym_r   <= dec_s;
                        idx_r   <= {IDX_W{1'b0}};
                        byte_r  <= dec_s[DATA_LENGTH-1:0];
                        valid_r <= 1'b1;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_EMIT: begin
                    if (cap_s) begin
                        sym_r  <= dec_s;
                        idx_r  <= {IDX_W{1'b0}};
                        byte_r <= dec_s[DATA_LENGTH-1:0];
                    end else if (last_s) begin
                        state_r <= ST_IDLE;
                        idx_r   <= {IDX_W{1'b0}};
                        valid_r <= 1'b0;
                        busy_r  <= 1'b0;
                    end else if (adv_s) begin
                        idx_r  <= nxt_idx_s;
                        byte_r <= sym_r[nxt_idx_s*DATA_LENGTH +: DATA_LENGTH];
                    end else begin
                        idx_r <= idx_r;
                    end
                    overrun_r <= i_FFT_cycle_done & ~last_s;
                end
                default: begin
                    state_r <= ST_IDLE;
                    valid_r <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

`ifdef OFDM_DEMAP_ERASURE_EN
    // Erasure flags travel with the symbol; the output flag is the OR over
    // the bins that make up the byte currently on o_byte.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            era_r     <= {POINTS{1'b0}};
            erasure_r <= 1'b0;
        end else if (cap_s) begin
            era_r     <= era_s;
            erasure_r <= |era_s[BINS_PER_BYTE-1:0];
        end else if (adv_s) begin
            erasure_r <= |era_r[nxt_idx_s*BINS_PER_BYTE +: BINS_PER_BYTE];
        end else begin
            erasure_r <= erasure_r;
        end
    end

    assign o_erasure = erasure_r;
`else
    assign o_erasure = 1'b0;
`endif

    assign o_byte       = byte_r;
    assign o_byte_valid = valid_r;
    assign o_busy       = busy_r;
    assign o_overrun    = overrun_r;

endmodule

// File: tb/tb_ofdm_qpsk_demapper.sv
// Testbench for ofdm_qpsk_demapper: table of symbol vectors with hand-derived
// expected words, a byte scoreboard fed at strobe time, and directed
// sequences for stalls, overrun, back-to-back symbols and mid-symbol reset.
// Honours OFDM_DEMAP_ERASURE_EN for the expected erasure flags.
module tb_ofdm_qpsk_demapper;

    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] bins_re;
    logic [255:0] bins_im;
    logic         strobe;
    logic [7:0]   o_byte;
    logic         o_byte_valid;
    logic         ready;
    logic         o_busy;
    logic         o_overrun;
    logic         o_erasure;

    int total = 0;
    int bad   = 0;
    int busy_cnt = 0;
    int hs_cnt   = 0;

    typedef struct {
        logic [255:0] re;
        logic [255:0] im;
        logic [31:0]  word;
        logic [3:0]   era;
    } vec_t;

    typedef struct {
        logic [7:0] b;
        logic       e;
    } exp_t;

    vec_t vecs[6];
    exp_t q[$];

    always #5 clk = ~clk;

    ofdm_qpsk_demapper dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_bins_re       (bins_re),
        .i_bins_im       (bins_im),
        .i_FFT_cycle_done(strobe),
        .o_byte          (o_byte),
        .o_byte_valid    (o_byte_valid),
        .i_byte_ready    (ready),
        .o_busy          (o_busy),
        .o_overrun       (o_overrun),
        .o_erasure       (o_erasure)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    function automatic logic [255:0] fill(input logic [15:0] v);
        logic [255:0] r;
        for (int k = 0; k < 16; k++) r[k*16 +: 16] = v;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_bins(input int i);
        bins_re = vecs[i].re;
        bins_im = vecs[i].im;
    endtask

    task automatic push_exp(input int i);
        exp_t x;
        for (int n = 0; n < 4; n++) begin
            x.b = vecs[i].word[8*n +: 8];
`ifdef OFDM_DEMAP_ERASURE_EN
            x.e = vecs[i].era[n];
`else
            x.e = 1'b0;
`endif
            q.push_back(x);
        end
    endtask

    // Called just after a rising edge; returns just after the capture edge.
    task automatic strobe_cycle(input int i, input bit push);
        apply_bins(i);
        strobe = 1'b1;
        if (push) push_exp(i);
        step();
        strobe = 1'b0;
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int c = 0; c < 80 && !done; c++) begin
            @(negedge clk);
            if (q.size() == 0 && !o_busy) done = 1'b1;
        end
        if (!done) chk("idle_timeout", 64'(q.size()), 64'd0);
        step();
    endtask

    // Monitor: scoreboard compare on each handshake, stall stability check.
    initial begin
        bit         stall_prev = 1'b0;
        logic [7:0] held_b = 8'h00;
        logic       held_e = 1'b0;
        exp_t       x;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (o_busy) busy_cnt++;
                if (stall_prev && o_byte_valid) begin
                    chk("stall_byte", 64'(o_byte), 64'(held_b));
                    chk("stall_erasure", 64'(o_erasure), 64'(held_e));
                end
                if (o_byte_valid && ready) begin
                    hs_cnt++;
                    if (q.size() == 0) begin
                        chk("byte_without_expect", 64'(q.size()), 64'd1);
                    end else begin
                        x = q.pop_front();
                        chk("byte", 64'(o_byte), 64'(x.b));
                        chk("erasure", 64'(o_erasure), 64'(x.e));
                    end
                end
                stall_prev = o_byte_valid && !ready;
                held_b     = o_byte;
                held_e     = o_erasure;
            end else begin
                stall_prev = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        // Vector table: word = expected symbol bits, era = per-byte erasure.
        for (int i = 0; i < 6; i++) begin
            vecs[i].re   = fill(16'h0100);
            vecs[i].im   = fill(16'h0100);
            vecs[i].word = 32'h0000_0000;
            vecs[i].era  = 4'b0000;
        end
        // 1: bin0 re<0, bin1 im=-1, bin15 both <0
        vecs[1].re[0*16 +: 16]  = 16'hFF00;
        vecs[1].im[1*16 +: 16]  = 16'hFFFF;
        vecs[1].re[15*16 +: 16] = 16'hFF00;
        vecs[1].im[15*16 +: 16] = 16'hFF00;
        vecs[1].word = 32'hC000_0009;
        vecs[1].era  = 4'b0001;
        // 2: everything negative
        vecs[2].re   = fill(16'hFF00);
        vecs[2].im   = fill(16'hFF00);
        vecs[2].word = 32'hFFFF_FFFF;
        // 3: real negative, imaginary positive
        vecs[3].re   = fill(16'hFF00);
        vecs[3].word = 32'h5555_5555;
        // 4: zero decides 0; bins 0..3 re=0 im<0, bins 4..7 re=-1 im=0
        for (int k = 0; k < 4; k++) begin
            vecs[4].re[k*16 +: 16]     = 16'h0000;
            vecs[4].im[k*16 +: 16]     = 16'hFF00;
            vecs[4].re[(k+4)*16 +: 16] = 16'hFFFF;
            vecs[4].im[(k+4)*16 +: 16] = 16'h0000;
        end
        vecs[4].word = 32'h0000_55AA;
        vecs[4].era  = 4'b0011;
        // 5: threshold corners: +8 erased, -32768 not, -16 not, +15 erased
        vecs[5].re[2*16 +: 16]  = 16'h0008;
        vecs[5].re[9*16 +: 16]  = 16'h8000;
        vecs[5].im[12*16 +: 16] = 16'hFFF0;
        vecs[5].re[13*16 +: 16] = 16'h000F;
        vecs[5].word = 32'h0204_0000;
        vecs[5].era  = 4'b1001;

        rst     = 1'b0;
        strobe  = 1'b0;
        ready   = 1'b0;
        bins_re = fill(16'h0100);
        bins_im = fill(16'h0100);
        step();
        step();
        chk("rst_byte", 64'(o_byte), 64'd0);
        chk("rst_valid", 64'(o_byte_valid), 64'd0);
        chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_overrun", 64'(o_overrun), 64'd0);
        chk("rst_erasure", 64'(o_erasure), 64'd0);
        rst = 1'b1;
        step();
        chk("idle_valid", 64'(o_byte_valid), 64'd0);

        // Table sweep with the sink always ready.
        ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            busy_cnt = 0;
            hs_cnt   = 0;
            strobe_cycle(i, 1'b1);
            chk("first_valid", 64'(o_byte_valid), 64'd1);
            wait_idle();
            chk("busy_cycles", 64'(busy_cnt), 64'd4);
            chk("handshakes", 64'(hs_cnt), 64'd4);
        end

        // Sink toggling ready: bytes held while stalled, exactly 4 handshakes.
        hs_cnt = 0;
        strobe_cycle(1, 1'b1);
        fork
            begin
                for (int c = 0; c < 14; c++) begin
                    step();
                    ready = ~ready;
                end
                ready = 1'b1;
            end
            wait_idle();
        join
        chk("toggle_handshakes", 64'(hs_cnt), 64'd4);
        step();

        // Strobe two cycles after the first one is dropped with a pulse.
        ready = 1'b1;
        strobe_cycle(2, 1'b1);
        step();
        apply_bins(3);
        strobe = 1'b1;
        step();
        strobe = 1'b0;
        chk("overrun_pulse", 64'(o_overrun), 64'd1);
        chk("overrun_valid", 64'(o_byte_valid), 64'd1);
        step();
        chk("overrun_clear", 64'(o_overrun), 64'd0);
        wait_idle();

        // Strobe on the final handshake: captured, no overrun, no gap.
        strobe_cycle(4, 1'b1);
        step();
        step();
        step();
        apply_bins(5);
        strobe = 1'b1;
        push_exp(5);
        step();
        strobe = 1'b0;
        chk("seam_overrun", 64'(o_overrun), 64'd0);
        chk("seam_valid", 64'(o_byte_valid), 64'd1);
        chk("seam_busy", 64'(o_busy), 64'd1);
        wait_idle();

        // Reset after the first of four bytes.
        strobe_cycle(3, 1'b1);
        step();
        rst = 1'b0;
        #1;
        chk("midrst_valid", 64'(o_byte_valid), 64'd0);
        chk("midrst_busy", 64'(o_busy), 64'd0);
        chk("midrst_pending", 64'(q.size()), 64'd3);
        q.delete();
        step();
        step();
        rst = 1'b1;
        for (int c = 0; c < 8; c++) step();
        chk("post_rst_valid", 64'(o_byte_valid), 64'd0);
        chk("post_rst_busy", 64'(o_busy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
